// File: rtl/pipe_mips32_hz.sv
// pipe_mips32_hz: single-clock 5-stage MIPS32 core with interlocks, branch flush and halt freeze.
// Build option FORWARDING_EN: EX/MEM and MEM/WB bypass into EX; when undefined, RAW hazards stall in ID.
module pipe_mips32_hz #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int NUM_REGS  = 32,
  parameter int CNT_W     = 32
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                  prog_data,
  input  logic [4:0]                   dbg_addr,
  output logic [DATA_W-1:0]            dbg_rdata,
  output logic                         halted,
  output logic [CNT_W-1:0]             retire_count
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);
  localparam int MW = (DATA_W > 32) ? DATA_W : 32;

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03,
                         OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09,
                         OP_ADDI = 6'h0a, OP_SUBI = 6'h0b, OP_SLTI = 6'h0c,
                         OP_BNEQZ = 6'h0d, OP_BEQZ = 6'h0e;

  typedef enum logic [2:0] {T_RR, T_RM, T_LW, T_SW, T_BR, T_HLT} itype_t;

  function automatic logic [RW-1:0] reg_idx(input logic [4:0] f);
    return RW'({27'd0, f} % NUM_REGS);
  endfunction

  function automatic logic [AW-1:0] maddr(input logic [DATA_W-1:0] v);
    return AW'(v % MEM_DEPTH);
  endfunction

  logic [MW-1:0]     mem [MEM_DEPTH];
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] pc_reg;
  logic              fetch_stop_reg, halted_reg;
  logic [CNT_W-1:0]  retire_count_reg;

  logic              if_id_valid;
  logic [31:0]       if_id_ir;
  logic [DATA_W-1:0] if_id_npc;

  logic              id_ex_valid, id_ex_wr;
  itype_t            id_ex_type;
  logic [5:0]        id_ex_op;
  logic [DATA_W-1:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;
  logic [RW-1:0]     id_ex_dest;
`ifdef FORWARDING_EN
  logic [RW-1:0]     id_ex_rs, id_ex_rt;
`endif

  logic              ex_mem_valid, ex_mem_wr;
  itype_t            ex_mem_type;
  logic [DATA_W-1:0] ex_mem_alu, ex_mem_b;
  logic [RW-1:0]     ex_mem_dest;

  logic              mem_wb_valid, mem_wb_wr;
  itype_t            mem_wb_type;
  logic [DATA_W-1:0] mem_wb_alu, mem_wb_lmd;
  logic [RW-1:0]     mem_wb_dest;

  // ID decode
  logic [5:0]        id_op;
  logic [RW-1:0]     id_rs, id_rt, id_dest;
  itype_t            id_type;
  logic              id_uses_rs, id_uses_rt, id_wr;
  logic [DATA_W-1:0] id_a, id_b, id_imm;

  always_comb begin
    id_op      = if_id_ir[31:26];
    id_rs      = reg_idx(if_id_ir[25:21]);
    id_rt      = reg_idx(if_id_ir[20:16]);
    id_type    = T_HLT;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    id_wr      = 1'b0;
    id_dest    = id_rt;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_type = T_RR; id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_wr = 1'b1;
        id_dest = reg_idx(if_id_ir[15:11]);
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        id_type = T_RM; id_uses_rs = 1'b1; id_wr = 1'b1;
      end
      OP_LW: begin
        id_type = T_LW; id_uses_rs = 1'b1; id_wr = 1'b1;
      end
      OP_SW: begin
        id_type = T_SW; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      end
      OP_BEQZ, OP_BNEQZ: begin
        id_type = T_BR; id_uses_rs = 1'b1;
      end
      default: ;
    endcase
  end

  logic              wb_we;
  logic [DATA_W-1:0] wb_value;
  assign wb_we    = mem_wb_valid && mem_wb_wr && (mem_wb_dest != '0);
  assign wb_value = (mem_wb_type == T_LW) ? mem_wb_lmd : mem_wb_alu;

  // Write-through: a WB write to the register being read is visible in the same cycle.
  assign id_a   = (wb_we && mem_wb_dest == id_rs) ? wb_value : regs[id_rs];
  assign id_b   = (wb_we && mem_wb_dest == id_rt) ? wb_value : regs[id_rt];
  assign id_imm = {{(DATA_W-16){if_id_ir[15]}}, if_id_ir[15:0]};

  // Hazard detection
  logic ex_hit, stall;
  assign ex_hit = id_ex_valid && id_ex_wr && (id_ex_dest != '0) &&
                  ((id_uses_rs && id_rs == id_ex_dest) || (id_uses_rt && id_rt == id_ex_dest));
`ifdef FORWARDING_EN
  assign stall = if_id_valid && ex_hit && (id_ex_type == T_LW);
`else
  logic mem_hit;
  assign mem_hit = ex_mem_valid && ex_mem_wr && (ex_mem_dest != '0) &&
                   ((id_uses_rs && id_rs == ex_mem_dest) || (id_uses_rt && id_rt == ex_mem_dest));
  assign stall = if_id_valid && (ex_hit || mem_hit);
`endif

  // EX operands, ALU and branch resolution
  logic [DATA_W-1:0] ex_a, ex_b, ex_alu;
  logic              taken;

  always_comb begin
    ex_a = id_ex_a;
    ex_b = id_ex_b;
`ifdef FORWARDING_EN
    // Loads in EX/MEM have no data yet; the load-use interlock covers that case.
    if (id_ex_rs != '0) begin
      if (ex_mem_valid && ex_mem_wr && ex_mem_type != T_LW && ex_mem_dest == id_ex_rs)
        ex_a = ex_mem_alu;
      else if (wb_we && mem_wb_dest == id_ex_rs)
        ex_a = wb_value;
    end
    if (id_ex_rt != '0) begin
      if (ex_mem_valid && ex_mem_wr && ex_mem_type != T_LW && ex_mem_dest == id_ex_rt)
        ex_b = ex_mem_alu;
      else if (wb_we && mem_wb_dest == id_ex_rt)
        ex_b = wb_value;
    end
`endif
    case (id_ex_op)
      OP_ADD:                   ex_alu = ex_a + ex_b;
      OP_SUB:                   ex_alu = ex_a - ex_b;
      OP_AND:                   ex_alu = ex_a & ex_b;
      OP_OR:                    ex_alu = ex_a | ex_b;
      OP_SLT:                   ex_alu = {{(DATA_W-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:                   ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW:    ex_alu = ex_a + id_ex_imm;
      OP_SUBI:                  ex_alu = ex_a - id_ex_imm;
      OP_SLTI:                  ex_alu = {{(DATA_W-1){1'b0}}, $signed(ex_a) < $signed(id_ex_imm)};
      OP_BEQZ, OP_BNEQZ:        ex_alu = id_ex_npc + id_ex_imm;
      default:                  ex_alu = '0;
    endcase
    taken = id_ex_valid && (id_ex_type == T_BR) &&
            ((id_ex_op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
  end

  // Unified memory: loader writes only while in reset or halted; stores come from MEM.
  always_ff @(posedge clk1) begin
    if (prog_we && (rst || halted_reg))
      mem[prog_addr] <= MW'(prog_data);
    else if (!rst && !halted_reg && ex_mem_valid && ex_mem_type == T_SW)
      mem[maddr(ex_mem_alu)] <= MW'(ex_mem_b);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_reg           <= '0;
      fetch_stop_reg   <= 1'b0;
      halted_reg       <= 1'b0;
      retire_count_reg <= '0;
      if_id_valid      <= 1'b0;
      if_id_ir         <= '0;
      if_id_npc        <= '0;
      id_ex_valid      <= 1'b0;
      id_ex_wr         <= 1'b0;
      id_ex_type       <= T_HLT;
      id_ex_op         <= '0;
      id_ex_a          <= '0;
      id_ex_b          <= '0;
      id_ex_imm        <= '0;
      id_ex_npc        <= '0;
      id_ex_dest       <= '0;
`ifdef FORWARDING_EN
      id_ex_rs         <= '0;
      id_ex_rt         <= '0;
`endif
      ex_mem_valid     <= 1'b0;
      ex_mem_wr        <= 1'b0;
      ex_mem_type      <= T_HLT;
      ex_mem_alu       <= '0;
      ex_mem_b         <= '0;
      ex_mem_dest      <= '0;
      mem_wb_valid     <= 1'b0;
      mem_wb_wr        <= 1'b0;
      mem_wb_type      <= T_HLT;
      mem_wb_alu       <= '0;
      mem_wb_lmd       <= '0;
      mem_wb_dest      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (!halted_reg) begin
      // WB
      if (wb_we) regs[mem_wb_dest] <= wb_value;
      if (mem_wb_valid) begin
        if (retire_count_reg != '1) retire_count_reg <= retire_count_reg + 1'b1;
        if (mem_wb_type == T_HLT) halted_reg <= 1'b1;
      end
      // MEM
      mem_wb_valid <= ex_mem_valid;
      mem_wb_wr    <= ex_mem_wr;
      mem_wb_type  <= ex_mem_type;
      mem_wb_alu   <= ex_mem_alu;
      mem_wb_dest  <= ex_mem_dest;
      mem_wb_lmd   <= mem[maddr(ex_mem_alu)][DATA_W-1:0];
      // EX
      ex_mem_valid <= id_ex_valid;
      ex_mem_wr    <= id_ex_wr;
      ex_mem_type  <= id_ex_type;
      ex_mem_alu   <= ex_alu;
      ex_mem_b     <= ex_b;
      ex_mem_dest  <= id_ex_dest;
      // ID: a taken branch flushes the instruction in ID even if it was stalled
      id_ex_valid  <= if_id_valid && !taken && !stall;
      id_ex_wr     <= id_wr;
      id_ex_type   <= id_type;
      id_ex_op     <= id_op;
      id_ex_a      <= id_a;
      id_ex_b      <= id_b;
      id_ex_imm    <= id_imm;
      id_ex_npc    <= if_id_npc;
      id_ex_dest   <= id_dest;
`ifdef FORWARDING_EN
      id_ex_rs     <= id_rs;
      id_ex_rt     <= id_rt;
`endif
      // IF
      if (taken) begin
        pc_reg      <= ex_alu;
        if_id_valid <= 1'b0;
      end else if (stall) begin
        pc_reg      <= pc_reg;
      end else if (fetch_stop_reg || (if_id_valid && id_type == T_HLT)) begin
        if_id_valid    <= 1'b0;
        fetch_stop_reg <= 1'b1;
      end else begin
        if_id_ir    <= mem[maddr(pc_reg)][31:0];
        if_id_npc   <= pc_reg + DATA_W'(1);
        if_id_valid <= 1'b1;
        pc_reg      <= pc_reg + DATA_W'(1);
      end
    end
  end

  assign dbg_rdata    = regs[reg_idx(dbg_addr)];
  assign halted       = halted_reg;
  assign retire_count = retire_count_reg;
endmodule

// File: tb/tb_pipe_mips32_hz.sv
// Directed bench for pipe_mips32_hz: loads small programs through the load port and checks results/timing.
module tb_pipe_mips32_hz;
  localparam logic [5:0] OP_ADD = 6'h00, OP_LW = 6'h08, OP_SW = 6'h09, OP_ADDI = 6'h0a,
                         OP_SUBI = 6'h0b, OP_BNEQZ = 6'h0d, OP_BEQZ = 6'h0e, OP_HLT = 6'h3f;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;
  logic        halted;
  logic [31:0] retire_count;

  int          n_pass = 0;
  int          n_checks = 0;
  logic [31:0] prog [32];
  logic [31:0] hlt_word;

  always #5 clk1 = ~clk1;

  pipe_mips32_hz dut (
    .clk1(clk1), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .halted(halted), .retire_count(retire_count)
  );

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_addr = 5'(idx);
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic load_prog(input int n);
    rst = 1'b1;
    @(negedge clk1);
    for (int i = 0; i < n; i++) begin
      prog_addr = 10'(i);
      prog_data = prog[i];
      prog_we   = 1'b1;
      @(negedge clk1);
    end
    prog_we = 1'b0;
  endtask

  // Releases reset at a falling edge and counts rising edges until halted (edge 1 = first after release).
  task automatic run_until_halt(input int pulse_edge, output int edges);
    rst   = 1'b0;
    edges = 0;
    while (!halted && edges < 400) begin
      @(posedge clk1);
      #1;
      edges++;
      prog_we   = (edges == pulse_edge);
      prog_addr = 10'd3;
      prog_data = hlt_word;
    end
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int n, input int exp_edges, input int exp_retire);
    int e;
    load_prog(n);
    run_until_halt(-1, e);
    $display("%s: halted after edge %0d, retired %0d", tag, e, retire_count);
    check({tag, "_halt_edge"}, 32'(e), 32'(exp_edges));
    check({tag, "_retire"}, retire_count, 32'(exp_retire));
  endtask

  initial begin
    int e;
    logic [31:0] rc;
    hlt_word = {OP_HLT, 26'd0};

    #1 rst = 1'b1;
    #1;
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    check_reg("reset_r3", 3, 32'd0);

    // Basic RAW chain
    prog[0] = enc_i(OP_ADDI, 1, 0, 10);
    prog[1] = enc_i(OP_ADDI, 2, 0, 20);
    prog[2] = enc_r(OP_ADD, 3, 1, 2);
    prog[3] = hlt_word;
    run_prog("add", 4, FWD ? 8 : 10, 4);
    check_reg("add_r3", 3, 32'd30);

    // Store, load and load-use
    prog[0] = enc_i(OP_ADDI, 1, 0, 120);
    prog[1] = enc_i(OP_SW, 1, 0, 50);
    prog[2] = enc_i(OP_LW, 4, 0, 50);
    prog[3] = enc_r(OP_ADD, 5, 4, 4);
    prog[4] = hlt_word;
    run_prog("ldst", 5, FWD ? 10 : 13, 5);
    check_reg("ldst_r4", 4, 32'd120);
    check_reg("ldst_r5", 5, 32'd240);

    // Taken branch skips two instructions
    prog[0] = enc_i(OP_ADDI, 1, 0, 0);
    prog[1] = enc_i(OP_BEQZ, 0, 1, 2);
    prog[2] = enc_i(OP_ADDI, 6, 0, 1);
    prog[3] = enc_i(OP_ADDI, 7, 0, 1);
    prog[4] = enc_i(OP_ADDI, 8, 0, 5);
    prog[5] = hlt_word;
    run_prog("beqz", 6, FWD ? 10 : 12, 4);
    check_reg("beqz_r6", 6, 32'd0);
    check_reg("beqz_r7", 7, 32'd0);
    check_reg("beqz_r8", 8, 32'd5);

    // Same program, branch not taken
    prog[1] = enc_i(OP_BNEQZ, 0, 1, 2);
    run_prog("bneqz", 6, FWD ? 10 : 12, 6);
    check_reg("bneqz_r6", 6, 32'd1);
    check_reg("bneqz_r7", 7, 32'd1);
    check_reg("bneqz_r8", 8, 32'd5);

    // R0 stays zero and is never forwarded
    prog[0] = enc_i(OP_ADDI, 9, 0, 3);
    prog[1] = enc_i(OP_ADDI, 0, 0, 7);
    prog[2] = enc_r(OP_ADD, 9, 0, 0);
    prog[3] = hlt_word;
    run_prog("r0", 4, 8, 4);
    check_reg("r0_r0", 0, 32'd0);
    check_reg("r0_r9", 9, 32'd0);

    // Countdown loop: 1 + 10*2 + 2 retired, 9 taken branches
    prog[0] = enc_i(OP_ADDI, 10, 0, 10);
    prog[1] = enc_i(OP_SUBI, 10, 10, 1);
    prog[2] = enc_i(OP_BNEQZ, 0, 10, -2);
    prog[3] = enc_i(OP_ADDI, 11, 0, 77);
    prog[4] = hlt_word;
    run_prog("loop", 5, FWD ? 45 : 67, 23);
    check_reg("loop_r10", 10, 32'd0);
    check_reg("loop_r11", 11, 32'd77);
    rc = retire_count;
    repeat (5) @(posedge clk1);
    #1;
    $display("loop: 5 edges after halt, retired %0d", retire_count);
    check("frozen_retire", retire_count, rc);
    check("frozen_halted", {31'd0, halted}, 32'd1);
    check_reg("frozen_r11", 11, 32'd77);

    // Asynchronous reset mid-run, then rerun with an ignored load pulse
    load_prog(5);
    rst = 1'b0;
    repeat (20) @(posedge clk1);
    #1 rst = 1'b1;
    #1;
    $display("midrun reset: halted %0d, retired %0d", halted, retire_count);
    check("midrun_retire", retire_count, 32'd0);
    check("midrun_halted", {31'd0, halted}, 32'd0);
    check_reg("midrun_r10", 10, 32'd0);
    @(negedge clk1);
    run_until_halt(2, e);
    $display("rerun: halted after edge %0d, retired %0d", e, retire_count);
    check("rerun_halt_edge", 32'(e), FWD ? 32'd45 : 32'd67);
    check("rerun_retire", retire_count, 32'd23);
    check_reg("rerun_r11", 11, 32'd77);
    check_reg("rerun_r10", 10, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
